// File: rtl/tt_mult_pkg.sv
// Shared constants and types for the 8x8 shift-add multiplier.
// MULT_SIGNED_EN selects two's-complement operands; the default build is unsigned.
package tt_mult_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int N_ITER = 8;
    localparam int CNT_W  = $clog2(N_ITER);

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // uio_in command bits
    localparam int UIO_LOAD_A   = 0;
    localparam int UIO_LOAD_B   = 1;
    localparam int UIO_START    = 2;
    localparam int UIO_BYTE_SEL = 3;

    // uio_out status bits
    localparam int UIO_BUSY = 4;
    localparam int UIO_DONE = 5;
    localparam int UIO_OVF  = 6;

    localparam logic [7:0] UIO_OE = 8'b0111_0000;

endpackage

// File: rtl/mult_core.sv
// Shift-add datapath: one bit of B per step, LSB first, into a 16-bit accumulator.
// With MULT_SIGNED_EN the magnitudes are multiplied and the result negated on sign mismatch.
module mult_core
    import tt_mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic              last_o,
    output logic [PROD_W-1:0] prod_o,
    output logic              ovf_o
);

    logic [PROD_W-1:0] a_sh_q, a_sh_d;
    logic [OP_W-1:0]   b_sh_q, b_sh_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;

    logic [OP_W-1:0]   a_mag, b_mag;
    logic              neg_in;
    logic [PROD_W-1:0] sum, result;
    logic              ovf_calc;

`ifdef MULT_SIGNED_EN
    assign a_mag    = a_i[OP_W-1] ? (~a_i + {{(OP_W-1){1'b0}}, 1'b1}) : a_i;
    assign b_mag    = b_i[OP_W-1] ? (~b_i + {{(OP_W-1){1'b0}}, 1'b1}) : b_i;
    assign neg_in   = a_i[OP_W-1] ^ b_i[OP_W-1];
    assign result   = neg_q ? (~sum + PROD_W'(1)) : sum;
    // Representable as a signed byte only if the top nine bits are a pure sign extension
    assign ovf_calc = !((&result[PROD_W-1:OP_W-1]) || !(|result[PROD_W-1:OP_W-1]));
`else
    assign a_mag    = a_i;
    assign b_mag    = b_i;
    assign neg_in   = 1'b0;
    assign result   = sum;
    assign ovf_calc = |result[PROD_W-1:OP_W];
`endif

    assign sum    = acc_q + (b_sh_q[0] ? a_sh_q : '0);
    assign last_o = (cnt_q == CNT_W'(N_ITER - 1));

    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        neg_d  = neg_q;
        prod_d = prod_q;
        ovf_d  = ovf_q;
        if (load_i) begin
            a_sh_d = {{(PROD_W-OP_W){1'b0}}, a_mag};
            b_sh_d = b_mag;
            acc_d  = '0;
            cnt_d  = '0;
            neg_d  = neg_in;
            ovf_d  = 1'b0;
        end else if (step_i) begin
            acc_d  = sum;
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q >> 1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last_o) begin
                prod_d = result;
                ovf_d  = ovf_calc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            prod_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            neg_q  <= neg_d;
            prod_q <= prod_d;
            ovf_q  <= ovf_d;
        end
    end

    assign prod_o = prod_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/tt_um_multiplier.sv
// Top: pin decode, start edge detection, IDLE/RUN/DONE control and output muxing.
// Build with MULT_SIGNED_EN for two's-complement operands.
module tt_um_multiplier
    import tt_mult_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
    logic              start_q;

    logic              idle_or_done;
    logic              load_a, load_b, any_load;
    logic              start_acc;
    logic              step;
    logic              core_last;
    logic              core_ovf;
    logic [PROD_W-1:0] prod;
    logic              unused_uio;

    assign unused_uio   = &{1'b0, uio_in[7:4]};

    assign idle_or_done = ena && (state_q != ST_RUN);
    assign load_a       = uio_in[UIO_LOAD_A] && idle_or_done;
    assign load_b       = uio_in[UIO_LOAD_B] && idle_or_done;
    assign any_load     = load_a || load_b;
    assign start_acc    = uio_in[UIO_START] && !start_q && idle_or_done;
    assign step         = ena && (state_q == ST_RUN);

    assign a_d = load_a ? ui_in : a_q;
    assign b_d = load_b ? ui_in : b_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_acc) state_d = ST_RUN;
            ST_RUN:  if (step && core_last) state_d = ST_DONE;
            ST_DONE: begin
                if (start_acc)     state_d = ST_RUN;
                else if (any_load) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // start_q tracks the pin every cycle so a held start never looks like a new edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            start_q <= uio_in[UIO_START];
        end
    end

    mult_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (start_acc),
        .step_i (step),
        .a_i    (a_q),
        .b_i    (b_q),
        .last_o (core_last),
        .prod_o (prod),
        .ovf_o  (core_ovf)
    );

    assign uo_out = uio_in[UIO_BYTE_SEL] ? prod[PROD_W-1:OP_W] : prod[OP_W-1:0];

    always_comb begin
        uio_out           = '0;
        uio_out[UIO_BUSY] = (state_q == ST_RUN);
        uio_out[UIO_DONE] = (state_q == ST_DONE);
        uio_out[UIO_OVF]  = core_ovf && (state_q == ST_DONE);
    end

    assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_tt_um_multiplier.sv
// Directed bench for tt_um_multiplier; expectations follow MULT_SIGNED_EN when defined.
module tb_tt_um_multiplier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic       load_a, load_b, start, bsel;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_tests = 0;
    int n_fail  = 0;

    assign uio_in = {4'b0000, bsel, start, load_b, load_a};

    always #5 clk = ~clk;

    tt_um_multiplier dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
        ui_in = a; load_a = 1'b1; cyc(1); load_a = 1'b0;
        ui_in = b; load_b = 1'b1; cyc(1); load_b = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00;
        load_a = 1'b0; load_b = 1'b0; start = 1'b0; bsel = 1'b0;
        #2;
        n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out: got %h expected 00", uo_out); end
        n_tests++; if (uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out: got %h expected 00", uio_out); end
        n_tests++; if (uio_oe !== 8'h70) begin n_fail++; $display("FAIL reset_uio_oe: got %h expected 70", uio_oe); end
        cyc(2); rst_n = 1'b1; cyc(1);
        n_tests++; if (uio_out !== 8'h00) begin n_fail++; $display("FAIL idle_after_reset: got %h expected 00", uio_out); end
        $display("[TB] reset: uo_out=%h uio_out=%h uio_oe=%h", uo_out, uio_out, uio_oe);
    endtask

    task automatic test_ena_gating;
        ena = 1'b0;
        load_ops(8'h77, 8'h03);
        pulse_start;
        n_tests++; if (uio_out[4] !== 1'b0) begin n_fail++; $display("FAIL ena_low_start: busy got %b expected 0", uio_out[4]); end
        cyc(1);
        ena = 1'b1;
        pulse_start;
        n_tests++; if (uio_out[4] !== 1'b1) begin n_fail++; $display("FAIL ena_high_start: busy got %b expected 1", uio_out[4]); end
        cyc(8);
        n_tests++; if (uio_out[5] !== 1'b1) begin n_fail++; $display("FAIL ena_done: done got %b expected 1", uio_out[5]); end
        bsel = 1'b0; #1;
        n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL ena_no_load_lo: got %h expected 00", uo_out); end
        bsel = 1'b1; #1;
        n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL ena_no_load_hi: got %h expected 00", uo_out); end
        bsel = 1'b0;
        $display("[TB] ena gating: product lo/hi = 00/%h", uo_out);
    endtask

    task automatic test_products;
        logic [7:0]  va [5];
        logic [7:0]  vb [5];
        logic [15:0] vp [5];
        logic        vo [5];
        logic [15:0] prev;
        va[0] = 8'd13;  vb[0] = 8'd11;
        va[1] = 8'hFF;  vb[1] = 8'hFF;
        va[2] = 8'hFD;  vb[2] = 8'h05;
        va[3] = 8'h80;  vb[3] = 8'h80;
        va[4] = 8'hFF;  vb[4] = 8'h02;
`ifdef MULT_SIGNED_EN
        vp[0] = 16'h008F; vo[0] = 1'b1;
        vp[1] = 16'h0001; vo[1] = 1'b0;
        vp[2] = 16'hFFF1; vo[2] = 1'b0;
        vp[3] = 16'h4000; vo[3] = 1'b1;
        vp[4] = 16'hFFFE; vo[4] = 1'b0;
`else
        vp[0] = 16'h008F; vo[0] = 1'b0;
        vp[1] = 16'hFE01; vo[1] = 1'b1;
        vp[2] = 16'h04F1; vo[2] = 1'b1;
        vp[3] = 16'h4000; vo[3] = 1'b1;
        vp[4] = 16'h01FE; vo[4] = 1'b1;
`endif
        prev = 16'h0000;
        for (int v = 0; v < 5; v++) begin
            load_ops(va[v], vb[v]);
            pulse_start;
            bsel = 1'b1; #1;
            n_tests++; if (uo_out !== prev[15:8]) begin n_fail++; $display("FAIL prev_while_busy[%0d]: got %h expected %h", v, uo_out, prev[15:8]); end
            bsel = 1'b0;
            for (int k = 0; k < 8; k++) begin
                n_tests++;
                if (uio_out[5:4] !== 2'b01) begin
                    n_fail++; $display("FAIL busy_window[%0d] N+%0d: done,busy got %b expected 01", v, k, uio_out[5:4]);
                end
                cyc(1);
            end
            n_tests++; if (uio_out !== {1'b0, vo[v], 6'b100000}) begin n_fail++; $display("FAIL status[%0d]: got %h expected %h", v, uio_out, {1'b0, vo[v], 6'b100000}); end
            bsel = 1'b0; #1;
            n_tests++; if (uo_out !== vp[v][7:0]) begin n_fail++; $display("FAIL prod_lo[%0d]: got %h expected %h", v, uo_out, vp[v][7:0]); end
            bsel = 1'b1; #1;
            n_tests++; if (uo_out !== vp[v][15:8]) begin n_fail++; $display("FAIL prod_hi[%0d]: got %h expected %h", v, uo_out, vp[v][15:8]); end
            bsel = 1'b0;
            $display("[TB] mult %h*%h: expected %h ovf %b, uio_out=%h", va[v], vb[v], vp[v], vo[v], uio_out);
            prev = vp[v];
        end
    endtask

    task automatic test_zero_repeat;
        load_ops(8'h00, 8'd200);
        for (int r = 0; r < 2; r++) begin
            pulse_start;
            n_tests++; if (uio_out[5:4] !== 2'b01) begin n_fail++; $display("FAIL zero_start[%0d]: done,busy got %b expected 01", r, uio_out[5:4]); end
            cyc(8);
            n_tests++; if (uio_out !== 8'h20) begin n_fail++; $display("FAIL zero_status[%0d]: got %h expected 20", r, uio_out); end
            bsel = 1'b0; #1;
            n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL zero_lo[%0d]: got %h expected 00", r, uo_out); end
            bsel = 1'b1; #1;
            n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL zero_hi[%0d]: got %h expected 00", r, uo_out); end
            bsel = 1'b0;
            $display("[TB] zero*200 run %0d: uio_out=%h", r, uio_out);
        end
    endtask

    task automatic test_ignore_in_run;
        load_ops(8'd7, 8'd9);
        for (int r = 0; r < 2; r++) begin
            pulse_start;
            cyc(2);
            if (r == 0) begin
                ui_in = 8'hFF; load_a = 1'b1; start = 1'b1;
            end
            cyc(1);
            load_a = 1'b0; start = 1'b0;
            cyc(4);
            n_tests++; if (uio_out[5:4] !== 2'b01) begin n_fail++; $display("FAIL run_n7[%0d]: done,busy got %b expected 01", r, uio_out[5:4]); end
            cyc(1);
            n_tests++; if (uio_out !== 8'h20) begin n_fail++; $display("FAIL run_n8[%0d]: got %h expected 20", r, uio_out); end
            bsel = 1'b0; #1;
            n_tests++; if (uo_out !== 8'h3F) begin n_fail++; $display("FAIL run_lo[%0d]: got %h expected 3f", r, uo_out); end
            bsel = 1'b1; #1;
            n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL run_hi[%0d]: got %h expected 00", r, uo_out); end
            bsel = 1'b0;
            $display("[TB] 7*9 with in-run noise run %0d: uio_out=%h", r, uio_out);
        end
    endtask

    task automatic test_held_start;
        load_ops(8'd3, 8'd4);
        start = 1'b1;
        cyc(9);
        n_tests++; if (uio_out !== 8'h20) begin n_fail++; $display("FAIL held_done: got %h expected 20", uio_out); end
        cyc(4);
        n_tests++; if (uio_out !== 8'h20) begin n_fail++; $display("FAIL held_no_retrigger: got %h expected 20", uio_out); end
        start = 1'b0;
        cyc(1);
        #1;
        n_tests++; if (uo_out !== 8'h0C) begin n_fail++; $display("FAIL held_lo: got %h expected 0c", uo_out); end
        ui_in = 8'd5; load_a = 1'b1; cyc(1); load_a = 1'b0;
        n_tests++; if (uio_out !== 8'h00) begin n_fail++; $display("FAIL load_clears_done: got %h expected 00", uio_out); end
        #1;
        n_tests++; if (uo_out !== 8'h0C) begin n_fail++; $display("FAIL load_keeps_prod: got %h expected 0c", uo_out); end
        $display("[TB] held start / load clears done: uio_out=%h uo_out=%h", uio_out, uo_out);
    endtask

    task automatic test_reset_abort;
        load_ops(8'd7, 8'd9);
        pulse_start;
        cyc(4);
        bsel = 1'b0;
        rst_n = 1'b0; #1;
        n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL abort_uo_out: got %h expected 00", uo_out); end
        n_tests++; if (uio_out !== 8'h00) begin n_fail++; $display("FAIL abort_uio_out: got %h expected 00", uio_out); end
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        pulse_start;
        cyc(7);
        n_tests++; if (uio_out[5:4] !== 2'b01) begin n_fail++; $display("FAIL abort_rerun_n7: done,busy got %b expected 01", uio_out[5:4]); end
        cyc(1);
        n_tests++; if (uio_out !== 8'h20) begin n_fail++; $display("FAIL abort_rerun_n8: got %h expected 20", uio_out); end
        bsel = 1'b0; #1;
        n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL abort_rerun_lo: got %h expected 00", uo_out); end
        bsel = 1'b1; #1;
        n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL abort_rerun_hi: got %h expected 00", uo_out); end
        bsel = 1'b0;
        $display("[TB] reset abort and rerun: uio_out=%h", uio_out);
    endtask

    initial begin
        test_reset;
        test_ena_gating;
        test_products;
        test_zero_repeat;
        test_ignore_in_run;
        test_held_start;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
